ccip_trace_buffer: RTL and testbench

//  Armable on-chip trace of CCI-P traffic. Taps Rx/Tx port structs and pck_cp2af_error.

---
 rtl/ccip_trace_buffer.sv | 249 ++++++++++++++++++++++++
 tb/tb_ccip_trace_buffer.sv | 361 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ccip_trace_buffer.sv
// Minimal CCI-P port structs (only the fields the trace tap looks at) followed
// by the trace buffer itself: S1 input register, capture FSM, ring RAM with an
// indexed read port, and six saturating per-channel event counters.
package ccip_if_pkg;
    typedef struct packed {
        logic [511:0] data;
        logic         rspValid;
        logic         mmioRdValid;
        logic         mmioWrValid;
    } t_if_ccip_c0_Rx;

    typedef struct packed {
        logic rspValid;
    } t_if_ccip_c1_Rx;

    typedef struct packed {
        t_if_ccip_c0_Rx c0;
        t_if_ccip_c1_Rx c1;
    } t_if_ccip_Rx;

    typedef struct packed {
        logic valid;
    } t_if_ccip_c0_Tx;

    typedef struct packed {
        logic [511:0] data;
        logic         valid;
    } t_if_ccip_c1_Tx;

    typedef struct packed {
        logic [63:0] data;
        logic        mmioRdValid;
    } t_if_ccip_c2_Tx;

    typedef struct packed {
        t_if_ccip_c0_Tx c0;
        t_if_ccip_c1_Tx c1;
        t_if_ccip_c2_Tx c2;
    } t_if_ccip_Tx;
endpackage

module ccip_trace_buffer
    import ccip_if_pkg::*;
#(
    parameter int DEPTH     = 512,
    parameter int DATA_W    = 16,
    parameter int TS_W      = 32,
    parameter int CNT_W     = 32,
    parameter int POST_TRIG = 64,
    localparam int AW       = $clog2(DEPTH),
    localparam int ENTRY_W  = TS_W + 6 + 2*DATA_W
) (
    input  logic                 pClk,
    input  logic                 pck_cp2af_softReset_n,
    input  logic                 pck_cp2af_error,
    input  t_if_ccip_Rx          pck_cp2af_sRx,
    input  t_if_ccip_Tx          pck_af2cp_sTx,
    input  logic [5:0]           cfg_ev_en,
    input  logic [5:0]           cfg_trig_mask,
    input  logic                 cfg_trig_on_err,
    input  logic                 ctl_arm,
    input  logic                 ctl_disarm,
    input  logic                 rd_en,
    input  logic [AW-1:0]        rd_idx,
    output logic                 rd_valid,
    output logic [ENTRY_W-1:0]   rd_data,
    output logic [1:0]           sts_state,
    output logic [AW:0]          sts_count,
    output logic                 sts_wrapped,
    output logic [AW-1:0]        sts_trig_idx,
    output logic [6*CNT_W-1:0]   evt_cnt
);
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_POST  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [AW:0]   DEPTH_C     = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] POST_TRIG_C = AW'(POST_TRIG);

    if (DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0 || POST_TRIG < 0 || POST_TRIG >= DEPTH ||
        DATA_W < 1 || DATA_W > 64) begin : g_bad_params
        $error("ccip_trace_buffer: illegal DEPTH/POST_TRIG/DATA_W combination");
    end

    logic               rst_n;
    logic [5:0]         tap_vec;
    logic [5:0]         s1_vec_reg;
    logic               s1_err_reg;
    logic [DATA_W-1:0]  s1_rx_data_reg;
    logic [DATA_W-1:0]  s1_tx_data_reg;
    logic [TS_W-1:0]    s1_ts_reg;
    logic [TS_W-1:0]    ts_reg;
    logic [5:0]         ev;
    logic               trig;
    logic               arm_eff;
    state_t             state_reg, state_next;
    logic               we, post_inc, trig_hit;
    logic [AW-1:0]      wr_ptr_reg, post_cnt_reg, trig_addr_reg, oldest, rd_addr;
    logic [AW:0]        count_reg;
    logic               wrapped_reg;
    logic [ENTRY_W-1:0] record;
    logic [ENTRY_W-1:0] mem [DEPTH];
    logic [ENTRY_W-1:0] rd_raw_reg;
    logic               rd_zero_reg;
    logic               unused_tap;

    assign rst_n = pck_cp2af_softReset_n;

    // Channel order: Rx.c0 rsp, Rx.c1 rsp, Rx MMIO (wr|rd), Tx.c0, Tx.c1, Tx.c2 MMIO rsp
    assign tap_vec = {pck_af2cp_sTx.c2.mmioRdValid, pck_af2cp_sTx.c1.valid, pck_af2cp_sTx.c0.valid,
                      pck_cp2af_sRx.c0.mmioWrValid | pck_cp2af_sRx.c0.mmioRdValid,
                      pck_cp2af_sRx.c1.rspValid, pck_cp2af_sRx.c0.rspValid};

    // Only the low DATA_W bits of each data bus are traced
    assign unused_tap = ^{pck_cp2af_sRx.c0.data[511:DATA_W], pck_af2cp_sTx.c1.data[511:DATA_W],
                          pck_af2cp_sTx.c2.data};

    // S1 stage: register taps once together with the timestamp of that cycle
    always_ff @(posedge pClk or negedge rst_n) begin
        if (!rst_n) begin
            s1_vec_reg     <= '0;
            s1_err_reg     <= 1'b0;
            s1_rx_data_reg <= '0;
            s1_tx_data_reg <= '0;
            s1_ts_reg      <= '0;
            ts_reg         <= '0;
        end else begin
            s1_vec_reg     <= tap_vec;
            s1_err_reg     <= pck_cp2af_error;
            s1_rx_data_reg <= pck_cp2af_sRx.c0.data[DATA_W-1:0];
            s1_tx_data_reg <= pck_af2cp_sTx.c1.data[DATA_W-1:0];
            s1_ts_reg      <= ts_reg;
            ts_reg         <= ts_reg + TS_W'(1);
        end
    end

    assign ev      = s1_vec_reg & cfg_ev_en;
    assign trig    = (|(s1_vec_reg & cfg_trig_mask)) | (cfg_trig_on_err & s1_err_reg);
    assign arm_eff = ctl_arm & ~ctl_disarm;
    assign record  = {s1_ts_reg, ev, s1_rx_data_reg, s1_tx_data_reg};

    // Capture FSM state register
    always_ff @(posedge pClk or negedge rst_n) begin
        if (!rst_n) state_reg <= ST_IDLE;
        else        state_reg <= state_next;
    end

    // Next state and write strobes; disarm beats arm, arm restarts from any state
    always_comb begin
        state_next = state_reg;
        we         = 1'b0;
        post_inc   = 1'b0;
        trig_hit   = 1'b0;
        if (ctl_disarm) begin
            state_next = ST_IDLE;
        end else if (ctl_arm) begin
            state_next = ST_ARMED;
        end else begin
            case (state_reg)
                ST_ARMED: begin
                    we = |ev;
                    if (trig) begin
                        state_next = ST_POST;
                        trig_hit   = 1'b1;
                    end
                end
                ST_POST: begin
                    if (post_cnt_reg == POST_TRIG_C) begin
                        state_next = ST_DONE;
                    end else if (|ev) begin
                        we       = 1'b1;
                        post_inc = 1'b1;
                        if (post_cnt_reg + AW'(1) == POST_TRIG_C) state_next = ST_DONE;
                    end
                end
                default: ;
            endcase
        end
    end

    // Ring pointer, fill level, wrap flag, post-trigger count and trigger address
    always_ff @(posedge pClk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg    <= '0;
            count_reg     <= '0;
            wrapped_reg   <= 1'b0;
            post_cnt_reg  <= '0;
            trig_addr_reg <= '0;
        end else if (arm_eff) begin
            wr_ptr_reg    <= '0;
            count_reg     <= '0;
            wrapped_reg   <= 1'b0;
            post_cnt_reg  <= '0;
            trig_addr_reg <= '0;
        end else begin
            if (we) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
                if (count_reg == DEPTH_C) wrapped_reg <= 1'b1;
                else                      count_reg   <= count_reg + (AW+1)'(1);
            end
            if (post_inc) post_cnt_reg <= post_cnt_reg + AW'(1);
            // Trigger record (or the next record if none this cycle) lands at wr_ptr
            if (trig_hit) trig_addr_reg <= wr_ptr_reg;
        end
    end

    assign oldest  = wrapped_reg ? wr_ptr_reg : '0;
    assign rd_addr = oldest + rd_idx;

    // Ring RAM: write port plus registered read (read-before-write on collision)
    always_ff @(posedge pClk) begin
        if (we)    mem[wr_ptr_reg] <= record;
        if (rd_en) rd_raw_reg      <= mem[rd_addr];
    end

    // Read response flags; reads past the fill level return zero
    always_ff @(posedge pClk or negedge rst_n) begin
        if (!rst_n) begin
            rd_valid    <= 1'b0;
            rd_zero_reg <= 1'b1;
        end else begin
            rd_valid <= rd_en;
            if (rd_en) rd_zero_reg <= ({1'b0, rd_idx} >= count_reg);
        end
    end

    assign rd_data = rd_zero_reg ? '0 : rd_raw_reg;

    for (genvar gi = 0; gi < 6; gi++) begin : g_evt
        logic [CNT_W-1:0] cnt_reg;

        // Saturating event counter, independent of state and cfg_ev_en
        always_ff @(posedge pClk or negedge rst_n) begin
            if (!rst_n)                              cnt_reg <= '0;
            else if (arm_eff)                        cnt_reg <= '0;
            else if (s1_vec_reg[gi] && cnt_reg != '1) cnt_reg <= cnt_reg + CNT_W'(1);
        end

        assign evt_cnt[gi*CNT_W +: CNT_W] = cnt_reg;
    end

    assign sts_state    = state_reg;
    assign sts_count    = count_reg;
    assign sts_wrapped  = wrapped_reg;
    assign sts_trig_idx = (state_reg == ST_POST || state_reg == ST_DONE) ? (trig_addr_reg - oldest) : '0;
endmodule

// File: tb/tb_ccip_trace_buffer.sv
// Directed bench for ccip_trace_buffer: small ring (DEPTH=8), POST_TRIG=3, 4-bit counters.
`timescale 1ns/1ps
module tb_ccip_trace_buffer;
    import ccip_if_pkg::*;

    localparam int DEPTH = 8;
    localparam int DW    = 16;
    localparam int TSW   = 32;
    localparam int CW    = 4;
    localparam int PT    = 3;
    localparam int AW    = 3;
    localparam int EW    = TSW + 6 + 2*DW;

    localparam logic [6:0] RX0 = 7'h01;
    localparam logic [6:0] RX1 = 7'h02;
    localparam logic [6:0] MWR = 7'h04;
    localparam logic [6:0] MRD = 7'h08;
    localparam logic [6:0] TX0 = 7'h10;
    localparam logic [6:0] TX1 = 7'h20;
    localparam logic [6:0] TX2 = 7'h40;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              err;
    t_if_ccip_Rx       rx;
    t_if_ccip_Tx       tx;
    logic [5:0]        ev_en, trig_mask;
    logic              trig_on_err, arm, disarm, rd_en;
    logic [AW-1:0]     rd_idx;
    logic              rd_valid;
    logic [EW-1:0]     rd_data;
    logic [1:0]        st;
    logic [AW:0]       cnt;
    logic              wrapped;
    logic [AW-1:0]     tidx;
    logic [6*CW-1:0]   evt;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [6:0]    raw;
        logic [DW-1:0] rxd;
        logic [DW-1:0] txd;
        logic [5:0]    ev;
    } vec_t;

    always #5 clk = ~clk;

    ccip_trace_buffer #(
        .DEPTH(DEPTH), .DATA_W(DW), .TS_W(TSW), .CNT_W(CW), .POST_TRIG(PT)
    ) dut (
        .pClk(clk),
        .pck_cp2af_softReset_n(rst_n),
        .pck_cp2af_error(err),
        .pck_cp2af_sRx(rx),
        .pck_af2cp_sTx(tx),
        .cfg_ev_en(ev_en),
        .cfg_trig_mask(trig_mask),
        .cfg_trig_on_err(trig_on_err),
        .ctl_arm(arm),
        .ctl_disarm(disarm),
        .rd_en(rd_en),
        .rd_idx(rd_idx),
        .rd_valid(rd_valid),
        .rd_data(rd_data),
        .sts_state(st),
        .sts_count(cnt),
        .sts_wrapped(wrapped),
        .sts_trig_idx(tidx),
        .evt_cnt(evt)
    );

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end else begin
            $display("ok   %s = %0h", name, act);
        end
    endtask

    task automatic drive(input logic [6:0] raw, input logic [DW-1:0] rxd, input logic [DW-1:0] txd);
        rx = '0;
        tx = '0;
        rx.c0.rspValid    = raw[0];
        rx.c1.rspValid    = raw[1];
        rx.c0.mmioWrValid = raw[2];
        rx.c0.mmioRdValid = raw[3];
        tx.c0.valid       = raw[4];
        tx.c1.valid       = raw[5];
        tx.c2.mmioRdValid = raw[6];
        rx.c0.data        = 512'(rxd);
        tx.c1.data        = 512'(txd);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse(input logic [6:0] raw, input logic [DW-1:0] rxd, input logic [DW-1:0] txd);
        drive(raw, rxd, txd);
        tick();
        drive(7'h0, '0, '0);
    endtask

    task automatic settle();
        tick();
        tick();
    endtask

    task automatic do_arm();
        arm = 1'b1;
        tick();
        arm = 1'b0;
    endtask

    task automatic read_rec(input int idx, output logic [EW-1:0] rec);
        rd_en  = 1'b1;
        rd_idx = AW'(idx);
        tick();
        rd_en  = 1'b0;
        check($sformatf("rd_valid_idx%0d", idx), 128'(rd_valid), 128'(1));
        rec = rd_data;
    endtask

    function automatic logic [TSW-1:0] f_ts(input logic [EW-1:0] r);
        return r[EW-1 -: TSW];
    endfunction

    function automatic logic [5:0] f_ev(input logic [EW-1:0] r);
        return r[2*DW+5 -: 6];
    endfunction

    function automatic logic [DW-1:0] f_tx(input logic [EW-1:0] r);
        return r[DW-1:0];
    endfunction

    function automatic logic [CW-1:0] evt_ch(input int i);
        return evt[i*CW +: CW];
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t          tbl [8];
        logic [EW-1:0] r, r0, r1, r2;
        logic [TSW-1:0] ts_first, ts_last;
        int            n;
        int            exp_evt [6];

        drive(7'h0, '0, '0);
        err = 1'b0; ev_en = 6'h3F; trig_mask = 6'h00; trig_on_err = 1'b0;
        arm = 1'b0; disarm = 1'b0; rd_en = 1'b0; rd_idx = '0;
        ts_first = '0; ts_last = '0;

        // Reset state
        #23 rst_n = 1'b1;
        tick();
        check("rst_state",    128'(st),       128'(0));
        check("rst_count",    128'(cnt),      128'(0));
        check("rst_wrapped",  128'(wrapped),  128'(0));
        check("rst_trig_idx", 128'(tidx),     128'(0));
        check("rst_evt",      128'(evt),      128'(0));
        check("rst_rd_valid", 128'(rd_valid), 128'(0));
        check("rst_rd_data",  128'(rd_data),  128'(0));

        // Three Tx.c0 pulses at cycles 10, 11, 20
        do_arm();
        check("arm_state", 128'(st), 128'(1));
        for (int c = 0; c <= 20; c++) begin
            if (c == 10 || c == 11 || c == 20) drive(TX0, '0, '0);
            else                               drive(7'h0, '0, '0);
            tick();
        end
        drive(7'h0, '0, '0);
        settle();
        check("t1_count", 128'(cnt), 128'(3));
        read_rec(0, r0);
        read_rec(1, r1);
        read_rec(2, r2);
        check("t1_ev0", 128'(f_ev(r0)), 128'(6'b001000));
        check("t1_ev1", 128'(f_ev(r1)), 128'(6'b001000));
        check("t1_ev2", 128'(f_ev(r2)), 128'(6'b001000));
        check("t1_dts01", 128'(TSW'(f_ts(r1) - f_ts(r0))), 128'(1));
        check("t1_dts12", 128'(TSW'(f_ts(r2) - f_ts(r1))), 128'(9));

        // Table of one-cycle input patterns applied on consecutive cycles
        tbl[0] = '{RX0 | TX1, 16'hA5A5, 16'h5A5A, 6'b010001};
        tbl[1] = '{TX0,       16'h1111, 16'h2222, 6'b001000};
        tbl[2] = '{MWR,       16'h3333, 16'h4444, 6'b000100};
        tbl[3] = '{MRD,       16'h5555, 16'h6666, 6'b000100};
        tbl[4] = '{MWR | MRD, 16'h7777, 16'h8888, 6'b000100};
        tbl[5] = '{7'h00,     16'h9999, 16'hAAAA, 6'b000000};
        tbl[6] = '{RX1,       16'hBBBB, 16'hCCCC, 6'b000010};
        tbl[7] = '{TX2,       16'hDDDD, 16'hEEEE, 6'b100000};

        do_arm();
        check("tbl_rearm_count", 128'(cnt), 128'(0));
        for (int i = 0; i < 8; i++) begin
            drive(tbl[i].raw, tbl[i].rxd, tbl[i].txd);
            tick();
        end
        drive(7'h0, '0, '0);
        settle();
        n = 0;
        for (int ch = 0; ch < 6; ch++) exp_evt[ch] = 0;
        for (int i = 0; i < 8; i++) begin
            for (int ch = 0; ch < 6; ch++) exp_evt[ch] += int'(tbl[i].ev[ch]);
            if (tbl[i].ev != 6'b0) begin
                read_rec(n, r);
                check($sformatf("tbl%0d_rec", i), 128'(r[2*DW+5:0]),
                      128'({tbl[i].ev, tbl[i].rxd, tbl[i].txd}));
                if (i == 0) ts_first = f_ts(r);
                if (i == 7) ts_last  = f_ts(r);
                n++;
            end
        end
        check("tbl_count", 128'(cnt), 128'(n));
        check("tbl_dts", 128'(TSW'(ts_last - ts_first)), 128'(7));
        for (int ch = 0; ch < 6; ch++)
            check($sformatf("tbl_evt%0d", ch), 128'(evt_ch(ch)), 128'(exp_evt[ch]));

        // cfg_ev_en filters records but not counters
        ev_en = 6'b000001;
        do_arm();
        pulse(RX0 | TX0, 16'h0101, 16'h0202);
        pulse(TX0, 16'h0303, 16'h0404);
        settle();
        ev_en = 6'h3F;
        check("mask_count", 128'(cnt), 128'(1));
        read_rec(0, r);
        check("mask_rec", 128'(r[2*DW+5:0]), 128'({6'b000001, 16'h0101, 16'h0202}));
        check("mask_evt3", 128'(evt_ch(3)), 128'(2));
        check("mask_evt0", 128'(evt_ch(0)), 128'(1));

        // Wrap: 11 events into an 8-entry ring
        do_arm();
        for (int i = 1; i <= 11; i++) begin
            drive(TX0, '0, DW'(i));
            tick();
        end
        drive(7'h0, '0, '0);
        settle();
        check("wrap_flag",  128'(wrapped), 128'(1));
        check("wrap_count", 128'(cnt),     128'(8));
        check("wrap_state", 128'(st),      128'(1));
        read_rec(0, r);
        check("wrap_idx0", 128'(f_tx(r)), 128'(4));
        read_rec(7, r);
        check("wrap_idx7", 128'(f_tx(r)), 128'(11));
        check("wrap_evt3", 128'(evt_ch(3)), 128'(11));

        // Trigger on Rx.c1 after 5 Tx.c0 records; 3 post records then DONE
        trig_mask = 6'b000010;
        do_arm();
        for (int i = 1; i <= 5; i++) begin
            drive(TX0, '0, DW'(i));
            tick();
        end
        for (int i = 6; i <= 12; i++) begin
            drive(RX1, '0, DW'(i));
            tick();
        end
        drive(7'h0, '0, '0);
        settle();
        trig_mask = 6'h00;
        check("trig_state",   128'(st),      128'(3));
        check("trig_count",   128'(cnt),     128'(8));
        check("trig_wrapped", 128'(wrapped), 128'(1));
        check("trig_idx",     128'(tidx),    128'(4));
        read_rec(4, r);
        check("trig_rec_ev", 128'(f_ev(r)), 128'(6'b000010));
        check("trig_rec_tx", 128'(f_tx(r)), 128'(6));
        read_rec(0, r);
        check("trig_oldest_tx", 128'(f_tx(r)), 128'(2));
        read_rec(7, r);
        check("trig_last_tx", 128'(f_tx(r)), 128'(9));

        // Error-only trigger, then disarm+arm in the same cycle
        trig_on_err = 1'b1;
        do_arm();
        pulse(TX0, '0, 16'd1);
        pulse(TX0, '0, 16'd2);
        err = 1'b1;
        tick();
        err = 1'b0;
        settle();
        check("err_state", 128'(st), 128'(2));
        pulse(TX0, '0, 16'd3);
        settle();
        check("err_trig_idx", 128'(tidx), 128'(2));
        read_rec(2, r);
        check("err_next_rec", 128'(f_tx(r)), 128'(3));
        check("err_still_post", 128'(st), 128'(2));
        disarm = 1'b1;
        arm    = 1'b1;
        tick();
        disarm = 1'b0;
        arm    = 1'b0;
        trig_on_err = 1'b0;
        check("disarm_wins_state", 128'(st),  128'(0));
        check("disarm_keep_count", 128'(cnt), 128'(3));
        read_rec(0, r);
        check("disarm_readable", 128'(f_tx(r)), 128'(1));

        // Counter saturation at 2^CW-1
        do_arm();
        check("sat_cleared", 128'(evt_ch(1)), 128'(0));
        for (int i = 0; i < 20; i++) begin
            drive(RX1, '0, '0);
            tick();
        end
        drive(7'h0, '0, '0);
        settle();
        check("sat_evt1", 128'(evt_ch(1)), 128'(15));
        check("sat_evt0", 128'(evt_ch(0)), 128'(0));

        // Reads at or beyond the fill level return zero
        do_arm();
        pulse(TX0, '0, 16'h0077);
        pulse(TX0, '0, 16'h0088);
        settle();
        read_rec(2, r);
        check("oob_idx2", 128'(r), 128'(0));
        read_rec(7, r);
        check("oob_idx7", 128'(r), 128'(0));
        read_rec(1, r);
        check("inb_idx1", 128'(f_tx(r)), 128'(16'h0088));
        tick();
        check("rd_valid_idle", 128'(rd_valid), 128'(0));

        // Asynchronous reset while in POST
        trig_mask = 6'b000010;
        do_arm();
        pulse(RX1, '0, 16'd5);
        settle();
        check("post_before_rst", 128'(st), 128'(2));
        #2 rst_n = 1'b0;
        #1;
        check("arst_state",    128'(st),      128'(0));
        check("arst_count",    128'(cnt),     128'(0));
        check("arst_wrapped",  128'(wrapped), 128'(0));
        check("arst_trig_idx", 128'(tidx),    128'(0));
        check("arst_evt",      128'(evt),     128'(0));
        @(negedge clk);
        rst_n = 1'b1;
        trig_mask = 6'h00;
        tick();
        check("arst_after_state", 128'(st), 128'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
